// File: rtl/count_seq_if.sv
// Observed counter stream: the value bus, its sample qualifier and the
// observed design's reset. The master drives the stream and the checker listens.
interface count_seq_if #(
    parameter int W = 4
) ();
    logic [W-1:0] count;
    logic         count_valid;
    logic         dut_rst;

    modport master (output count, output count_valid, output dut_rst);
    modport slave  (input  count, input  count_valid, input  dut_rst);
endinterface

// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running +1 mod 2^W counter stream: it locks onto
// the sequence, flags breaks and keeps error, first-break and longest-run statistics.
module count_seq_checker #(
    parameter int W        = 4,
    parameter int LOCK_LEN = 2,
    parameter int RUN_W    = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    count_seq_if.slave          mon,
    input  logic                clear,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [W-1:0]        exp_cap,
    output logic [W-1:0]        obs_cap,
    output logic [RUN_W-1:0]    max_run
);

    typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

    localparam state_t RESYNC = (LOCK_LEN == 1) ? LOCKED : LOCKING;

    state_t              state, state_nxt;
    logic [W-1:0]        exp_val, exp_nxt;
    logic [RUN_W-1:0]    run, run_nxt, run_inc, max_base, max_nxt;
    logic [ERRCNT_W-1:0] cnt_base;
    logic                match, brk, upd, captured;

    // Next sequence state; a break is only a mismatch seen while LOCKED.
    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_val;
        run_nxt   = run;
        brk       = 1'b0;
        match     = (mon.count == exp_val);
        run_inc   = (&run) ? run : run + RUN_W'(1);
        if (mon.dut_rst) begin
            state_nxt = SEARCH;
            run_nxt   = '0;
        end else if (mon.count_valid) begin
            case (state)
                SEARCH: begin
                    exp_nxt   = mon.count + W'(1);
                    run_nxt   = RUN_W'(1);
                    state_nxt = RESYNC;
                end
                LOCKING: begin
                    if (match) begin
                        exp_nxt = exp_val + W'(1);
                        run_nxt = run_inc;
                        if (run_inc == RUN_W'(LOCK_LEN))
                            state_nxt = LOCKED;
                    end else begin
                        exp_nxt = mon.count + W'(1);
                        run_nxt = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        exp_nxt = exp_val + W'(1);
                        run_nxt = run_inc;
                    end else begin
                        brk       = 1'b1;
                        exp_nxt   = mon.count + W'(1);
                        run_nxt   = RUN_W'(1);
                        state_nxt = RESYNC;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // Statistics start from zero on clear, then fold in this edge's update.
    always_comb begin
        upd      = mon.dut_rst | mon.count_valid;
        cnt_base = clear ? '0 : err_count;
        max_base = clear ? '0 : max_run;
        max_nxt  = (upd && (run_nxt > max_base)) ? run_nxt : max_base;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            exp_val   <= '0;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            exp_cap   <= '0;
            obs_cap   <= '0;
            max_run   <= '0;
            captured  <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_val   <= exp_nxt;
            run       <= run_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= brk;
            max_run   <= max_nxt;
            if (brk)
                err_count <= (&cnt_base) ? cnt_base : cnt_base + ERRCNT_W'(1);
            else
                err_count <= cnt_base;
            // A break coinciding with clear counts as the first one after it.
            if (brk && (clear || !captured)) begin
                exp_cap  <= exp_val;
                obs_cap  <= mon.count;
                captured <= 1'b1;
            end else if (clear) begin
                exp_cap  <= '0;
                obs_cap  <= '0;
                captured <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker (W=4, LOCK_LEN=2, RUN_W=8, ERRCNT_W=4):
// a vector table for the main sequence plus hand-written saturation and reset sequences.
module tb_count_seq_checker;

    typedef struct {
        logic [3:0] cnt;
        logic       vld;
        logic       drst;
        logic       clr;
        logic       lk;
        logic       pl;
        logic [3:0] ec;
        logic [7:0] mr;
        logic [3:0] ecap;
        logic [3:0] ocap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       locked, err_pulse;
    logic [3:0] err_count, exp_cap, obs_cap;
    logic [7:0] max_run;
    int         checks = 0;
    int         fails = 0;
    logic [3:0] exp_model;
    vec_t       vecs[31];

    count_seq_if #(.W(4)) bus ();

    count_seq_checker #(.W(4), .LOCK_LEN(2), .RUN_W(8), .ERRCNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mon       (bus),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .exp_cap   (exp_cap),
        .obs_cap   (obs_cap),
        .max_run   (max_run)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int c, v, d, cl, lk, pl, ec, mr, ecap, ocap);
        vec_t t;
        t.cnt = 4'(c);  t.vld = 1'(v);   t.drst = 1'(d);  t.clr = 1'(cl);
        t.lk  = 1'(lk); t.pl  = 1'(pl);  t.ec   = 4'(ec); t.mr  = 8'(mr);
        t.ecap = 4'(ecap); t.ocap = 4'(ocap);
        return t;
    endfunction

    task automatic applyStimulus(input logic [3:0] c, input logic v, input logic d, input logic cl);
        @(negedge clk);
        bus.count       = c;
        bus.count_valid = v;
        bus.dut_rst     = d;
        clear           = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic checkAll(input string tag, input logic lk, input logic pl, input logic [3:0] ec,
                            input logic [7:0] mr, input logic [3:0] ecap, input logic [3:0] ocap);
        checkOutput({tag, " locked"},    32'(locked),    32'(lk));
        checkOutput({tag, " err_pulse"}, 32'(err_pulse), 32'(pl));
        checkOutput({tag, " err_count"}, 32'(err_count), 32'(ec));
        checkOutput({tag, " max_run"},   32'(max_run),   32'(mr));
        checkOutput({tag, " exp_cap"},   32'(exp_cap),   32'(ecap));
        checkOutput({tag, " obs_cap"},   32'(obs_cap),   32'(ocap));
    endtask

    // One break while locked (sample exp+3), then the resync sample that relocks.
    task automatic breakAndRelock(input string tag, input int exp_err);
        logic [3:0] b;
        b = exp_model + 4'd3;
        applyStimulus(b, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, " brk err_pulse"}, 32'(err_pulse), 32'd1);
        checkOutput({tag, " brk locked"},    32'(locked),    32'd0);
        checkOutput({tag, " brk err_count"}, 32'(err_count), 32'(exp_err));
        applyStimulus(b + 4'd1, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, " relock locked"},    32'(locked),    32'd1);
        checkOutput({tag, " relock err_pulse"}, 32'(err_pulse), 32'd0);
        exp_model = b + 4'd2;
    endtask

    initial begin
        //            cnt v d c  lk p ec mr ecap ocap
        vecs[0]  = mk(11, 1,0,0, 0,0,0, 1, 0,0);
        vecs[1]  = mk(12, 1,0,0, 1,0,0, 2, 0,0);
        vecs[2]  = mk(13, 1,0,0, 1,0,0, 3, 0,0);
        vecs[3]  = mk(14, 1,0,0, 1,0,0, 4, 0,0);
        vecs[4]  = mk(15, 1,0,0, 1,0,0, 5, 0,0);
        vecs[5]  = mk( 0, 1,0,0, 1,0,0, 6, 0,0);
        vecs[6]  = mk( 1, 1,0,0, 1,0,0, 7, 0,0);
        vecs[7]  = mk( 9, 0,0,0, 1,0,0, 7, 0,0);
        vecs[8]  = mk( 5, 0,0,0, 1,0,0, 7, 0,0);
        vecs[9]  = mk(12, 0,0,0, 1,0,0, 7, 0,0);
        vecs[10] = mk( 2, 1,0,0, 1,0,0, 8, 0,0);
        vecs[11] = mk( 3, 1,0,0, 1,0,0, 9, 0,0);
        vecs[12] = mk( 4, 1,0,0, 1,0,0,10, 0,0);
        vecs[13] = mk( 5, 1,0,0, 1,0,0,11, 0,0);
        vecs[14] = mk( 6, 1,0,0, 1,0,0,12, 0,0);
        vecs[15] = mk( 7, 1,0,0, 1,0,0,13, 0,0);
        vecs[16] = mk( 8, 1,0,0, 1,0,0,14, 0,0);
        vecs[17] = mk( 7, 1,0,0, 0,1,1,14, 9,7);
        vecs[18] = mk( 8, 1,0,0, 1,0,1,14, 9,7);
        vecs[19] = mk( 9, 1,0,0, 1,0,1,14, 9,7);
        vecs[20] = mk( 0, 1,1,0, 0,0,1,14, 9,7);
        vecs[21] = mk( 0, 1,1,0, 0,0,1,14, 9,7);
        vecs[22] = mk( 0, 1,0,0, 0,0,1,14, 9,7);
        vecs[23] = mk( 1, 1,0,0, 1,0,1,14, 9,7);
        vecs[24] = mk( 5, 1,0,0, 0,1,2,14, 9,7);
        vecs[25] = mk( 6, 1,0,0, 1,0,2,14, 9,7);
        vecs[26] = mk( 0, 1,0,1, 0,1,1, 1, 7,0);
        vecs[27] = mk( 1, 1,0,0, 1,0,1, 2, 7,0);
        vecs[28] = mk( 2, 1,0,0, 1,0,1, 3, 7,0);
        vecs[29] = mk( 9, 0,0,1, 1,0,0, 0, 0,0);
        vecs[30] = mk( 3, 1,0,0, 1,0,0, 4, 0,0);

        bus.count = '0;
        bus.count_valid = 1'b0;
        bus.dut_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].cnt, vecs[i].vld, vecs[i].drst, vecs[i].clr);
            checkAll($sformatf("vec%0d", i), vecs[i].lk, vecs[i].pl, vecs[i].ec,
                     vecs[i].mr, vecs[i].ecap, vecs[i].ocap);
        end

        // Saturation: 20 breaks against a 4-bit error counter.
        exp_model = 4'd4;
        for (int i = 0; i < 20; i++)
            breakAndRelock($sformatf("sat%0d", i), (i + 1 > 15) ? 15 : i + 1);
        checkAll("saturated", 1, 0, 15, 4, 4, 7);

        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkAll("clear", 1, 0, 0, 0, 0, 0);

        // Build err_count=5, then reset asynchronously between edges.
        for (int i = 0; i < 5; i++)
            breakAndRelock($sformatf("pre%0d", i), i + 1);
        checkOutput("pre-reset err_count", 32'(err_count), 32'd5);
        @(negedge clk);
        bus.count_valid = 1'b0;
        clear = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkAll("async reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b0);
        checkAll("post-reset 3", 0, 0, 0, 1, 0, 0);
        applyStimulus(4'd4, 1'b1, 1'b0, 1'b0);
        checkAll("post-reset 4", 1, 0, 0, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
